// File: rtl/nco_pkg.sv
// Shared NCO definitions: table geometry and the loader state encoding,
// used by the loader, counter and readback blocks.
package nco_pkg;

  localparam int NCO_ADDR_W  = 8;
  localparam int NCO_DATA_W  = 16;
  localparam int NCO_MAX_LEN = 512;

  typedef enum logic [2:0] {
    IDLE,
    GET_LO,
    GET_HI,
    WRITE,
    DONE
  } loader_state_t;

endpackage

// File: rtl/sine_table_loader.sv
// Writer side of the NCO sine-table RAMs: packs a byte stream (low byte first)
// into 16-bit samples and issues single-cycle writes into two 256-entry banks.
module sine_table_loader
  import nco_pkg::*;
#(
  parameter int ADDR_W  = NCO_ADDR_W,
  parameter int DATA_W  = NCO_DATA_W,
  parameter int MAX_LEN = NCO_MAX_LEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [9:0]        n_words,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              csb0,
  output logic [ADDR_W-1:0] addr0,
  output logic [DATA_W-1:0] din0,
  output logic              csb1,
  output logic [ADDR_W-1:0] addr1,
  output logic [DATA_W-1:0] din1,
  output logic              busy,
  output logic              done,
  output logic [9:0]        word_count
);

  localparam logic [9:0] MAX_LEN_W = 10'(MAX_LEN);

  loader_state_t     state_reg, state_next;
  logic [ADDR_W:0]   ptr_reg;
  logic [9:0]        len_reg;
  logic [7:0]        lo_reg;

  logic              handshake;
  logic              accept_start;
  logic              last_word;
  logic [9:0]        ptr_inc;
  logic [9:0]        len_clipped;
  logic [DATA_W-1:0] word_packed;

  assign handshake    = in_valid & in_ready;
  assign accept_start = start & ~abort & ((state_reg == IDLE) | (state_reg == DONE));
  assign ptr_inc      = 10'(ptr_reg) + 10'd1;
  assign last_word    = (ptr_inc == len_reg);
  assign len_clipped  = ((n_words == 10'd0) || (n_words > MAX_LEN_W)) ? MAX_LEN_W : n_words;
  assign word_packed  = DATA_W'({in_byte, lo_reg});

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: if (accept_start) state_next = GET_LO;
      GET_LO: begin
        if (abort)          state_next = IDLE;
        else if (handshake) state_next = GET_HI;
      end
      GET_HI: begin
        if (abort)          state_next = IDLE;
        else if (handshake) state_next = WRITE;
      end
      WRITE: begin
        if (abort)          state_next = IDLE;
        else if (last_word) state_next = DONE;
        else                state_next = GET_LO;
      end
      default:              state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      ptr_reg    <= '0;
      len_reg    <= '0;
      lo_reg     <= '0;
      in_ready   <= 1'b0;
      csb0       <= 1'b1;
      csb1       <= 1'b1;
      addr0      <= '0;
      addr1      <= '0;
      din0       <= '0;
      din1       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      word_count <= '0;
    end else begin
      state_reg <= state_next;
      // Ready follows the next state so it is up in the same cycle as GET_LO/GET_HI.
      in_ready  <= (state_next == GET_LO) || (state_next == GET_HI);
      csb0      <= 1'b1;
      csb1      <= 1'b1;
      case (state_reg)
        IDLE, DONE: begin
          if (accept_start) begin
            len_reg    <= len_clipped;
            ptr_reg    <= '0;
            word_count <= '0;
            done       <= 1'b0;
            busy       <= 1'b1;
          end
        end
        GET_LO: begin
          if (abort)          busy   <= 1'b0;
          else if (handshake) lo_reg <= in_byte;
        end
        GET_HI: begin
          if (abort) begin
            busy <= 1'b0;
          end else if (handshake) begin
            // Write strobe is registered here so it is low for exactly the WRITE cycle.
            if (ptr_reg[ADDR_W]) begin
              csb1  <= 1'b0;
              addr1 <= ptr_reg[ADDR_W-1:0];
              din1  <= word_packed;
            end else begin
              csb0  <= 1'b0;
              addr0 <= ptr_reg[ADDR_W-1:0];
              din0  <= word_packed;
            end
          end
        end
        WRITE: begin
          // The write in this cycle is committed even when abort arrives with it.
          word_count <= ptr_inc;
          ptr_reg    <= (ADDR_W + 1)'(ptr_inc);
          if (abort) begin
            busy <= 1'b0;
          end else if (last_word) begin
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        default: busy <= 1'b0;
      endcase
    end
  end

endmodule
